// File: rtl/stage_map_pkg.sv
// Shared definitions for the stage-map server: map geometry, block codes
// and the load/run state encoding used by stage_map_server.
package stage_map_pkg;

    localparam int MAP_COLS   = 256;
    localparam int MAP_ROWS   = 16;
    localparam int ROWS_VALID = 12;

    localparam int ADDR_W  = 12;
    localparam int BLOCK_W = 6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 12'hFFF;

    // Block codes understood by the renderer and game logic
    localparam logic [BLOCK_W-1:0] BLK_EMPTY    = 6'd0;
    localparam logic [BLOCK_W-1:0] BLK_GROUND   = 6'd1;
    localparam logic [BLOCK_W-1:0] BLK_BRICK    = 6'd2;
    localparam logic [BLOCK_W-1:0] BLK_COIN     = 6'd3;
    localparam logic [BLOCK_W-1:0] BLK_PIPE     = 6'd4;
    localparam logic [BLOCK_W-1:0] BLK_QUESTION = 6'd5;

    localparam logic [BLOCK_W-1:0] EMPTY_CODE = BLK_EMPTY;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } map_state_t;

endpackage

// File: rtl/stage_map_ram.sv
// 4096 x 6 synchronous RAM, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old data.
module stage_map_ram
    import stage_map_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [BLOCK_W-1:0] rdata
);

    logic [BLOCK_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write and registered read share the edge; the read sees pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/stage_map_server.sv
// Stage-map server: loads the tile map from the stage ROM, serves renderer
// lookups with one cycle of latency and accepts tile updates from game logic.
// Optional macro STAGE_MAP_COLLIDE_PORT_EN adds an independent collision
// read port backed by a second RAM copy written in parallel.
module stage_map_server
    import stage_map_pkg::*;
#(
    parameter int                 ROWS_VALID = stage_map_pkg::ROWS_VALID,
    parameter logic [BLOCK_W-1:0] EMPTY_CODE = stage_map_pkg::EMPTY_CODE
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  block_xpos,
    input  logic [3:0]  block_ypos,
    output logic [5:0]  block,
    input  logic        load_req,
    output logic [11:0] rom_addr,
    input  logic [5:0]  rom_data,
    output logic        load_busy,
    output logic        load_done,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_xpos,
    input  logic [3:0]  wr_ypos,
`ifdef STAGE_MAP_COLLIDE_PORT_EN
    input  logic [7:0]  col_xpos,
    input  logic [3:0]  col_ypos,
    output logic [5:0]  col_block,
`endif
    input  logic [5:0]  wr_block
);

    map_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [BLOCK_W-1:0] ram_wdata;
    logic [BLOCK_W-1:0] rd_data;
    logic               rd_ok_q;

    // State and load address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake outputs and RAM write source selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rom_addr  = '0;
        load_busy = 1'b0;
        load_done = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                load_busy = 1'b1;
                rom_addr  = cnt_q;
                cnt_d     = cnt_q + 12'd1;
                if (cnt_q != '0) begin
                    ram_we    = 1'b1;
                    ram_waddr = cnt_q - 12'd1;
                    ram_wdata = rom_data;
                end
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                load_busy = 1'b1;
                load_done = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = LAST_ADDR;
                ram_wdata = rom_data;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                wr_ready = 1'b1;
                if (wr_valid && (int'(wr_ypos) < ROWS_VALID)) begin
                    ram_we    = 1'b1;
                    ram_waddr = {wr_ypos, wr_xpos};
                    ram_wdata = wr_block;
                end
                if (load_req) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Remember whether the lookup issued this cycle may show real map data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= (state_q == ST_RUN) && (int'(block_ypos) < ROWS_VALID);
        end
    end

    stage_map_ram u_render_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({block_ypos, block_xpos}),
        .rdata (rd_data)
    );

    assign block = rd_ok_q ? rd_data : EMPTY_CODE;

`ifdef STAGE_MAP_COLLIDE_PORT_EN
    logic [BLOCK_W-1:0] col_data;
    logic               col_ok_q;

    // Same visibility rule as the renderer port, tracked independently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_ok_q <= 1'b0;
        end else begin
            col_ok_q <= (state_q == ST_RUN) && (int'(col_ypos) < ROWS_VALID);
        end
    end

    stage_map_ram u_collide_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({col_ypos, col_xpos}),
        .rdata (col_data)
    );

    assign col_block = col_ok_q ? col_data : EMPTY_CODE;
`endif

endmodule

// File: tb/tb_stage_map_server.sv
// Directed bench for stage_map_server: reset state, full stage load from a
// modulo-35 ROM model, table-driven RUN-phase reads/writes, and reset mid-load.
module tb_stage_map_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  block_xpos;
    logic [3:0]  block_ypos;
    logic [5:0]  block;
    logic        load_req;
    logic [11:0] rom_addr;
    logic [5:0]  rom_data;
    logic        load_busy;
    logic        load_done;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_xpos;
    logic [3:0]  wr_ypos;
    logic [5:0]  wr_block;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       wv;
        logic [7:0] wx;
        logic [3:0] wy;
        logic [5:0] wb;
        logic [7:0] rx;
        logic [3:0] ry;
        logic [5:0] eb;
    } vec_t;

    vec_t vecs [13];

    stage_map_server dut (
        .clk        (clk),
        .rst        (rst),
        .block_xpos (block_xpos),
        .block_ypos (block_ypos),
        .block      (block),
        .load_req   (load_req),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_xpos    (wr_xpos),
        .wr_ypos    (wr_ypos),
        .wr_block   (wr_block)
    );

    always #5 clk = ~clk;

    // Stage ROM model: data for an address appears one cycle later
    always @(posedge clk) begin
        rom_data <= 6'(rom_addr % 12'd35);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        wr_valid   = v.wv;
        wr_xpos    = v.wx;
        wr_ypos    = v.wy;
        wr_block   = v.wb;
        block_xpos = v.rx;
        block_ypos = v.ry;
        checkOutput($sformatf("wr_ready[%0d]", idx), 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput($sformatf("block[%0d]", idx), 32'(block), 32'(v.eb));
    endtask

    // Start a load and watch it; stop_at > 0 asserts reset at that cycle instead
    task automatic runLoad(input int stop_at, output int done_cycle, output int busy_cnt);
        done_cycle = -1;
        busy_cnt   = 0;
        @(negedge clk);
        load_req   = 1'b1;
        block_xpos = 8'd5;
        block_ypos = 4'd2;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (k == 1) load_req = 1'b0;
            if (stop_at > 0 && k == stop_at) begin
                rst = 1'b1;
                return;
            end
            if (k == 100) checkOutput("rom_addr_k100", 32'(rom_addr), 32'd99);
            if (k == 500) checkOutput("block_during_load", 32'(block), 32'd0);
            if (load_busy && !load_done) busy_cnt++;
            if (load_done) begin
                done_cycle = k;
                return;
            end
        end
    endtask

    initial begin
        int done_cycle;
        int busy_cnt;
        int errs;

        // RUN-phase vectors; RAM holds addr % 35 for rows 0..11 after the load
        vecs[0]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd5,   4'd2,  6'd27};
        vecs[1]  = '{1'b1, 8'd20,  4'd4,  6'd22, 8'd0,   4'd0,  6'd0};
        vecs[2]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd20,  4'd4,  6'd22};
        vecs[3]  = '{1'b1, 8'd7,   4'd1,  6'd11, 8'd3,   4'd0,  6'd3};
        vecs[4]  = '{1'b1, 8'd7,   4'd1,  6'd9,  8'd7,   4'd1,  6'd11};
        vecs[5]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd7,   4'd1,  6'd9};
        vecs[6]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd30,  4'd13, 6'd0};
        vecs[7]  = '{1'b1, 8'd30,  4'd13, 6'd5,  8'd30,  4'd13, 6'd0};
        vecs[8]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd30,  4'd13, 6'd0};
        vecs[9]  = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd255, 4'd11, 6'd26};
        vecs[10] = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd0,   4'd12, 6'd0};
        vecs[11] = '{1'b1, 8'd100, 4'd11, 6'd63, 8'd5,   4'd2,  6'd27};
        vecs[12] = '{1'b0, 8'd0,   4'd0,  6'd0,  8'd100, 4'd11, 6'd63};

        rst        = 1'b1;
        load_req   = 1'b0;
        wr_valid   = 1'b0;
        wr_xpos    = '0;
        wr_ypos    = '0;
        wr_block   = '0;
        block_xpos = '0;
        block_ypos = '0;

        // Reset state
        #1;
        checkOutput("rst_block",     32'(block),     32'd0);
        checkOutput("rst_rom_addr",  32'(rom_addr),  32'd0);
        checkOutput("rst_load_busy", 32'(load_busy), 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_wr_ready",  32'(wr_ready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        block_xpos = 8'd10;
        block_ypos = 4'd3;
        @(posedge clk);
        #1;
        checkOutput("idle_block",     32'(block),     32'd0);
        checkOutput("idle_wr_ready",  32'(wr_ready),  32'd0);
        checkOutput("idle_load_busy", 32'(load_busy), 32'd0);

        // Full load
        runLoad(0, done_cycle, busy_cnt);
        checkOutput("load_done_cycle", 32'(done_cycle), 32'd4097);
        checkOutput("load_busy_cycles", 32'(busy_cnt), 32'd4096);

        // Table-driven RUN-phase reads and writes
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], i);
        end
        @(negedge clk);
        wr_valid = 1'b0;

        // Reset in the middle of a load
        runLoad(2000, done_cycle, busy_cnt);
        #1;
        checkOutput("midrst_block",     32'(block),     32'd0);
        checkOutput("midrst_rom_addr",  32'(rom_addr),  32'd0);
        checkOutput("midrst_load_busy", 32'(load_busy), 32'd0);
        checkOutput("midrst_load_done", 32'(load_done), 32'd0);
        checkOutput("midrst_wr_ready",  32'(wr_ready),  32'd0);
        @(negedge clk);
        rst        = 1'b0;
        block_xpos = 8'd5;
        block_ypos = 4'd2;
        @(posedge clk);
        #1;
        checkOutput("partial_map_hidden", 32'(block), 32'd0);

        // Fresh load, then sweep the whole map
        runLoad(0, done_cycle, busy_cnt);
        checkOutput("reload_done_cycle", 32'(done_cycle), 32'd4097);
        errs = 0;
        for (int a = 0; a < 4096; a++) begin
            @(negedge clk);
            block_xpos = 8'(a);
            block_ypos = 4'(a >> 8);
            @(posedge clk);
            #1;
            if (block !== (((a >> 8) < 12) ? 6'(a % 35) : 6'd0)) errs++;
        end
        checkOutput("full_map_errors", 32'(errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stage_map_server.md
Name: stage_map_server

Overview:
- Responder side of the stage-map lookup used by the board renderer and game logic.
- Owns the stage tile RAM: 256 columns x 16 rows x 6-bit block code.
- Loads the map from an external stage ROM on request.
- Answers renderer lookups (block_xpos/block_ypos -> block) with fixed latency.
- Accepts tile updates from game logic (coin taken, brick broken) over a valid/ready port.

Parameters:
- ROWS_VALID, 12, rows 0..ROWS_VALID-1 hold map data; higher rows always read as empty.
- EMPTY_CODE, 0, block code returned for empty or unloaded tiles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- block_xpos  in  8  renderer column index
- block_ypos  in  4  renderer row index, 0 = bottom row
- block  out  6  block code for the requested tile
- load_req  in  1  one-cycle pulse: start a stage load
- rom_addr  out  12  stage ROM address, {ypos,xpos}
- rom_data  in  6  stage ROM data, valid 1 cycle after rom_addr
- load_busy  out  1  high while a load is in progress
- load_done  out  1  one-cycle pulse when a load completes
- wr_valid  in  1  tile update request
- wr_ready  out  1  update accepted when wr_valid && wr_ready
- wr_xpos  in  8  update column
- wr_ypos  in  4  update row
- wr_block  in  6  new block code

Behaviour:
- RAM: 4096 x 6, address = {ypos,xpos}. Contents are not cleared by rst.
- Outputs after reset: block = EMPTY_CODE, rom_addr = 0, load_busy = 0, load_done = 0, wr_ready = 0.
- FSM states:
  - IDLE: reached after reset; no map loaded.
  - LOAD: issuing ROM reads.
  - DRAIN: writing the last ROM word.
  - RUN: map valid, normal operation.
- Transitions:
  - IDLE or RUN, on load_req -> LOAD; address counter = 0.
  - LOAD, counter = 4095 -> DRAIN.
  - DRAIN -> RUN; load_done pulses in the same cycle.
- LOAD behaviour:
  - rom_addr = counter; counter increments every cycle.
  - rom_data is written to address (counter-1) on the following cycle.
  - DRAIN writes address 4095.
  - Total load time is 4097 cycles from load_req to load_done inclusive.
- load_req is ignored while in LOAD or DRAIN.
- load_busy is high in LOAD and DRAIN.
- Read path:
  - block is registered, 1-cycle latency: block(n+1) = RAM[{block_ypos,block_xpos}(n)].
  - block = EMPTY_CODE when block_ypos >= ROWS_VALID, or when the state is not RUN (IDLE, LOAD, DRAIN).
- Write port:
  - wr_ready = 1 only in RUN.
  - On handshake the RAM is written at that clock edge.
  - A write with wr_ypos >= ROWS_VALID is acknowledged but dropped.
- Same-cycle renderer read and write to the same address: read-first; block shows the old value, the new value appears on the next read.
- Reset mid-load: FSM -> IDLE, outputs return to reset values. A partially loaded RAM stays invisible because reads return EMPTY_CODE until the next completed load.

Optional Feature:
- Macro: STAGE_MAP_COLLIDE_PORT_EN.
- When defined, adds a second read port for player collision logic:
  - col_xpos in 8, col_ypos in 4, col_block out 6.
  - Same latency, out-of-range and not-RUN rules as the renderer port; independent of it.
  - Implemented as a duplicated RAM written in parallel.
- When undefined, these ports do not exist and only one RAM is instantiated.

Decomposition:
- Shared package:
  - block code constants (empty, ground, brick, coin, pipe, etc.);
  - MAP_COLS = 256, MAP_ROWS = 16, ROWS_VALID = 12;
  - FSM state encoding.
- One sub-module: stage_map_ram, a 4096x6 single-write / single-read synchronous RAM with read-first behaviour. It is instantiated once, or twice when STAGE_MAP_COLLIDE_PORT_EN is defined.

Test Plan:
- Reset, then read (10,3) -> block = 0, wr_ready = 0, load_busy = 0.
- load_req with ROM model data = (addr mod 35) -> load_busy high for 4096 cycles, load_done pulses at cycle 4097. Read (5,2), address 0x205 = 517 -> block = 27 one cycle later.
- In RUN, write (20,4) = 22 -> wr_ready = 1, handshake accepted; a read of (20,4) the next cycle returns 22.
- In RUN, write and read (7,1) in the same cycle with new value 9 and old value 11 -> block = 11, next read returns 9.
- Read (30,13) -> block = 0. Write (30,13) = 5 -> acknowledged, a later read still returns 0.
- Assert rst at load cycle 2000 -> outputs go to reset values, block = 0. A fresh load_req then completes normally and the full map matches the ROM.
